// File: rtl/mips_fetch_pkg.sv
// Shared fetch-path definitions: instruction memory geometry, FIFO entry layout
// and the fetch sequencer states.
package mips_fetch_pkg;

    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam int          IM_WORDS   = 1024;
    localparam int          WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN,
        ST_ERR
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch FIFO holding {pc, instruction} pairs between IM and decode.
// Head data reads as zero while the FIFO is empty.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] wr_pc,
    input  logic [31:0] wr_ins,
    output logic [31:0] head_pc,
    output logic [31:0] head_ins,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign head     = mem[rd_ptr];
    assign head_pc  = empty ? '0 : head.pc;
    assign head_ins = empty ? '0 : head.ins;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: wr_pc, ins: wr_ins};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational IM
// every cycle, queues words for decode and handles redirects and fetch faults.
module im_fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IM_BASE,
    parameter int          IM_DEPTH   = IM_WORDS,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_ins,
    output logic [31:0] dec_pc,
    output logic        fetch_err,
    output logic [31:0] err_pc
);
    localparam logic [31:0] LAST_PC = RESET_PC + 32'(WORD_BYTES * (IM_DEPTH - 1));

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  fetch_pc;
    logic [31:0]  pc_next;
    logic [31:0]  err_pc_next;
    logic         err_next;
    logic         run;
    logic         pc_ok;
    logic         push;
    logic         pop;
    logic         flush;
    logic         fifo_full;
    logic         fifo_empty;

    assign im_addr   = fetch_pc;
    assign run       = (state == ST_RUN);
    assign pc_ok     = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= RESET_PC) && (fetch_pc <= LAST_PC);
    assign dec_valid = !fifo_empty;
    assign pop       = dec_valid && dec_ready;
    // A faulting PC takes precedence over a redirect so queued work still drains.
    assign flush     = run && pc_ok && redirect_valid;
    assign push      = run && pc_ok && !redirect_valid && (!fifo_full || pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_pc    (fetch_pc),
        .wr_ins   (im_rdata),
        .head_pc  (dec_pc),
        .head_ins (dec_ins),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_next  = state;
        pc_next     = fetch_pc;
        err_next    = fetch_err;
        err_pc_next = err_pc;
        case (state)
            ST_RUN: begin
                if (!pc_ok) begin
                    state_next  = ST_ERR;
                    err_next    = 1'b1;
                    err_pc_next = fetch_pc;
                end else if (redirect_valid) begin
                    pc_next = redirect_target;
                end else if (push) begin
                    pc_next = fetch_pc + 32'(WORD_BYTES);
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            fetch_pc  <= RESET_PC;
            fetch_err <= 1'b0;
            err_pc    <= '0;
        end else begin
            state     <= state_next;
            fetch_pc  <= pc_next;
            fetch_err <= err_next;
            err_pc    <= err_pc_next;
        end
    end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: per-cycle vector table plus a
// scoreboard of the PCs decode is expected to receive, in order.
module tb_im_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_ins;
    logic [31:0] dec_pc;
    logic        fetch_err;
    logic [31:0] err_pc;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    typedef struct packed {
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [12];

    im_fetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .im_addr         (im_addr),
        .im_rdata        (im_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_ins         (dec_ins),
        .dec_pc          (dec_pc),
        .fetch_err       (fetch_err),
        .err_pc          (err_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        logic [31:0] idx;
        if (a < 32'h3000 || a > 32'h3FFC || a[1:0] != 2'b00) begin
            return 32'hDEAD_BEEF;
        end
        idx = (a - 32'h3000) >> 2;
        return 32'h1111_1111 * (idx + 32'd1);
    endfunction

    assign im_rdata = im_word(im_addr);

    function automatic vec_t mk(input logic rv, input logic [31:0] tgt, input logic rdy,
                                input logic [31:0] addr, input logic valid, input logic [31:0] pc);
        return '{rv: rv, tgt: tgt, rdy: rdy, addr: addr, valid: valid, pc: pc};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // A handshake seen here completes on the coming rising edge.
    task automatic scoreboard();
        logic [31:0] e;
        if (dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got pc %h expected no delivery", dec_pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_pc", dec_pc, e);
                checkOutput("sb_ins", dec_ins, im_word(e));
            end
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        reset           = 1'b0;
        redirect_valid  = rv;
        redirect_target = tgt;
        dec_ready       = rdy;
        #1;
        scoreboard();
    endtask

    task automatic doReset();
        @(negedge clk);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_im_addr", im_addr, 32'h3000);
        checkOutput("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("rst_dec_pc", dec_pc, 32'd0);
        checkOutput("rst_dec_ins", dec_ins, 32'd0);
        checkOutput("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
        checkOutput("rst_err_pc", err_pc, 32'd0);
    endtask

    task automatic checkDrained(input string name);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Straight-line run with decode always ready.
        doReset();
        for (int j = 0; j < 7; j++) exp_q.push_back(32'h3000 + 32'(4 * j));
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("p1_im_addr", im_addr, 32'h3000 + 32'(4 * k));
            checkOutput("p1_dec_valid", {31'b0, dec_valid}, (k == 0) ? 32'd0 : 32'd1);
        end
        checkDrained("p1_drained");

        // Backpressure, redirect with pop, then full-with-pop streaming.
        vecs[0]  = mk(1'b0, 32'h0,    1'b0, 32'h3000, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h0,    1'b0, 32'h3004, 1'b1, 32'h3000);
        vecs[2]  = mk(1'b0, 32'h0,    1'b0, 32'h3008, 1'b1, 32'h3000);
        vecs[3]  = mk(1'b0, 32'h0,    1'b0, 32'h3008, 1'b1, 32'h3000);
        vecs[4]  = mk(1'b0, 32'h0,    1'b0, 32'h3008, 1'b1, 32'h3000);
        vecs[5]  = mk(1'b1, 32'h3040, 1'b1, 32'h3008, 1'b1, 32'h3000);
        vecs[6]  = mk(1'b0, 32'h0,    1'b1, 32'h3040, 1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 32'h0,    1'b1, 32'h3044, 1'b1, 32'h3040);
        vecs[8]  = mk(1'b0, 32'h0,    1'b0, 32'h3048, 1'b1, 32'h3044);
        vecs[9]  = mk(1'b0, 32'h0,    1'b1, 32'h304C, 1'b1, 32'h3044);
        vecs[10] = mk(1'b0, 32'h0,    1'b1, 32'h3050, 1'b1, 32'h3048);
        vecs[11] = mk(1'b0, 32'h0,    1'b1, 32'h3054, 1'b1, 32'h304C);
        doReset();
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3040);
        exp_q.push_back(32'h3044);
        exp_q.push_back(32'h3048);
        exp_q.push_back(32'h304C);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rv, vecs[i].tgt, vecs[i].rdy);
            checkOutput("tbl_im_addr", im_addr, vecs[i].addr);
            checkOutput("tbl_dec_valid", {31'b0, dec_valid}, {31'b0, vecs[i].valid});
            checkOutput("tbl_dec_pc", dec_pc, vecs[i].pc);
            checkOutput("tbl_dec_ins", dec_ins, vecs[i].valid ? im_word(vecs[i].pc) : 32'd0);
        end
        checkDrained("tbl_drained");

        // Misaligned redirect target faults; later redirects are ignored.
        doReset();
        applyStimulus(1'b1, 32'h3042, 1'b1);
        checkOutput("bad_c0_im_addr", im_addr, 32'h3000);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("bad_c1_im_addr", im_addr, 32'h3042);
        checkOutput("bad_c1_dec_valid", {31'b0, dec_valid}, 32'd0);
        applyStimulus(1'b1, 32'h3000, 1'b1);
        checkOutput("bad_c2_fetch_err", {31'b0, fetch_err}, 32'd1);
        checkOutput("bad_c2_err_pc", err_pc, 32'h3042);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("bad_hold_im_addr", im_addr, 32'h3042);
            checkOutput("bad_hold_dec_valid", {31'b0, dec_valid}, 32'd0);
            checkOutput("bad_hold_fetch_err", {31'b0, fetch_err}, 32'd1);
            checkOutput("bad_hold_err_pc", err_pc, 32'h3042);
        end

        // Fall off the last IM word.
        doReset();
        exp_q.push_back(32'h3FFC);
        applyStimulus(1'b1, 32'h3FFC, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("end_c1_im_addr", im_addr, 32'h3FFC);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("end_c2_im_addr", im_addr, 32'h4000);
        checkOutput("end_c2_dec_valid", {31'b0, dec_valid}, 32'd1);
        checkOutput("end_c2_fetch_err", {31'b0, fetch_err}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("end_c3_fetch_err", {31'b0, fetch_err}, 32'd1);
        checkOutput("end_c3_err_pc", err_pc, 32'h4000);
        checkOutput("end_c3_dec_valid", {31'b0, dec_valid}, 32'd0);
        checkDrained("end_drained");

        // Asynchronous reset between edges with two entries queued.
        doReset();
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("ar_pre_dec_valid", {31'b0, dec_valid}, 32'd1);
        checkOutput("ar_pre_im_addr", im_addr, 32'h3008);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_dec_valid", {31'b0, dec_valid}, 32'd0);
        checkOutput("ar_im_addr", im_addr, 32'h3000);
        checkOutput("ar_dec_pc", dec_pc, 32'd0);
        checkOutput("ar_dec_ins", dec_ins, 32'd0);
        exp_q.delete();
        exp_q.push_back(32'h3000);
        exp_q.push_back(32'h3004);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("ar_c0_im_addr", im_addr, 32'h3000);
        checkOutput("ar_c0_dec_valid", {31'b0, dec_valid}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("ar_c1_im_addr", im_addr, 32'h3004);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkDrained("ar_drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
